fifo_stream_reader: RTL
=======================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning width of each FIFO word and stream word.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, meaning width of the delivered-word counter.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  read enable; when low, no new FIFO reads are issued.
REQ-006 SHALL have port fifo_empty  input  1  empty flag of the upstream synchronous FIFO.
REQ-007 SHALL have port fifo_dout  input  DATA_WIDTH  registered FIFO read data, valid the cycle after a FIFO read is accepted.
REQ-008 SHALL have port fifo_rd_en  output  1  FIFO read request.
REQ-009 SHALL have port m_valid  output  1  stream data valid.
REQ-010 SHALL have port m_ready  input  1  stream consumer ready.
REQ-011 SHALL have port m_data  output  DATA_WIDTH  stream data.
REQ-012 SHALL have port words_out  output  CNT_WIDTH  count of words delivered on the stream.
REQ-013 SHALL have port idle  output  1  high when the buffer is empty and no read is in flight.

Function
REQ-014 SHALL contain a 3-entry in-order output buffer (occupancy occ, 0..3) and a 1-bit in-flight flag (infl).
REQ-015 SHALL drive fifo_rd_en = en && !fifo_empty && (occ + infl < 3), from registered state and inputs only; no combinational path from m_ready to fifo_rd_en.
REQ-016 SHALL set infl to the value of fifo_rd_en on each clock edge (one-cycle FIFO read latency).
REQ-017 SHALL capture fifo_dout into the buffer tail on every edge where infl is 1; a capture SHALL never be dropped.
REQ-018 SHALL drive m_valid = (occ != 0) and m_data = buffer head entry.
REQ-019 SHALL treat a transfer as m_valid && m_ready on a rising edge; on transfer the head is popped.
REQ-020 SHALL update occ: +1 on capture only, -1 on transfer only, unchanged on both or neither.
REQ-021 SHALL, on simultaneous capture and transfer with occ = 1, load the captured word directly into the head.
REQ-022 SHALL hold m_data and m_valid stable while m_valid && !m_ready.
REQ-023 SHALL preserve FIFO order exactly; no duplication or loss.
REQ-024 SHALL give latency of 2 cycles from fifo_rd_en asserted (cycle N) to m_valid high (cycle N+2) when the buffer is empty.
REQ-025 SHALL sustain one word per cycle when FIFO is non-empty, en = 1 and m_ready = 1 continuously.
REQ-026 SHALL, when en falls, complete any in-flight capture and continue delivering buffered words.
REQ-027 SHALL increment words_out by 1 per transfer, saturating at all ones (no wrap).
REQ-028 SHALL drive idle = (occ == 0) && !infl.

Reset
REQ-029 SHALL, on rst high, asynchronously clear occ, infl, buffer pointers and words_out; fifo_rd_en, m_valid and words_out SHALL read 0, idle SHALL read 1, m_data SHALL read 0.
REQ-030 SHALL, on reset asserted mid-operation, discard buffered and in-flight words; the upstream FIFO is reset by the same rst.

Verification
REQ-031 Single word: FIFO holds 0xA5, en=1, m_ready=1 -> fifo_rd_en one cycle, m_valid high 2 cycles later with m_data=0xA5 for one cycle, words_out=1, idle returns 1.
REQ-032 Streaming: FIFO preloaded 0x01..0x0A, m_ready=1 -> ten consecutive cycles of m_valid with data 0x01..0x0A in order, words_out=10.
REQ-033 Backpressure: FIFO holds 0x10..0x15, m_ready=0 -> exactly 3 fifo_rd_en pulses, m_data held at 0x10; then m_ready=1 -> 0x10..0x15 delivered in order, none lost.
REQ-034 Empty guard: FIFO empty, en=1 for 20 cycles -> fifo_rd_en never asserted, m_valid stays 0.
REQ-035 Enable drop: en falls the cycle fifo_rd_en is high -> in-flight word still delivered, no further reads until en rises.
REQ-036 Reset mid-stream: rst pulsed with occ=2 -> m_valid, fifo_rd_en, words_out immediately 0, idle=1.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Pulls words from a synchronous FIFO with one-cycle read latency and presents them
// as a valid/ready stream through a 3-entry skid buffer, counting delivered words.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  words_out,
    output logic                  idle
);

    logic [DATA_WIDTH-1:0] data_reg [0:2];
    logic [1:0]            occ_reg;
    logic [1:0]            head_reg;
    logic [1:0]            tail_reg;
    logic                  infl_reg;
    logic [CNT_WIDTH-1:0]  words_reg;

    logic capture;
    logic transfer;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign capture  = infl_reg;
    assign transfer = (occ_reg != 2'd0) && m_ready;

    // Reserve a slot for the in-flight word so a capture always has room.
    assign fifo_rd_en = !rst && en && !fifo_empty &&
                        (({1'b0, occ_reg} + {2'b00, infl_reg}) < 3'd3);

    assign m_valid   = (occ_reg != 2'd0);
    assign m_data    = data_reg[head_reg];
    assign words_out = words_reg;
    assign idle      = (occ_reg == 2'd0) && !infl_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_reg   <= 2'd0;
            head_reg  <= 2'd0;
            tail_reg  <= 2'd0;
            infl_reg  <= 1'b0;
            words_reg <= '0;
            for (int i = 0; i < 3; i++) begin
                data_reg[i] <= '0;
            end
        end else begin
            infl_reg <= fifo_rd_en;
            // With occ=1 a simultaneous pop moves head onto the slot being written,
            // so the captured word becomes the new head directly.
            if (capture) begin
                data_reg[tail_reg] <= fifo_dout;
                tail_reg           <= ptr_inc(tail_reg);
            end
            if (transfer) begin
                head_reg <= ptr_inc(head_reg);
            end
            case ({capture, transfer})
                2'b10:   occ_reg <= occ_reg + 2'd1;
                2'b01:   occ_reg <= occ_reg - 2'd1;
                default: occ_reg <= occ_reg;
            endcase
            if (transfer && (words_reg != {CNT_WIDTH{1'b1}})) begin
                words_reg <= words_reg + 1'b1;
            end
        end
    end

endmodule
